pair_drain: RTL and testbench
=============================

# pair_drain

Downstream drain stage for the one-entry pair FIFO. It pulls a 64-bit value pair out through the FIFO's `first`/`deq` guarded methods and holds it in a local buffer. It then emits the pair as two 32-bit words through a guarded `enq` method on the next stage, and counts completed pairs. It gives the FIFO a consumer that frees its single slot early, one cycle after the pair is read, rather than after both words leave.

## Interface
Parameters:
- HI_FIRST, 0: word order; 0 = bits [31:0] first, 1 = bits [63:32] first.
- CNT_W, 16: width of the completed-pair counter.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  reset, synchronous, active-high.
- in_first  in  64  head value of upstream FIFO.
- in_first__RDY  in  1  head value is valid.
- in_deq__RDY  in  1  upstream deq method is ready.
- in_deq__ENA  out  1  fire upstream deq; never high unless in_deq__RDY and in_first__RDY are both high.
- out_enq_v  out  32  word offered downstream.
- out_enq__RDY  in  1  downstream enq method is ready.
- out_enq__ENA  out  1  fire downstream enq; never high unless out_enq__RDY is high.
- pair_count  out  CNT_W  number of completed pairs, modulo 2^CNT_W.
- idle  out  1  state is EMPTY.

## Operation
- State register `st` has three states: EMPTY, W0, W1. There is also a 64-bit `buf` register.
- `take` = in_first__RDY && in_deq__RDY.
- `send` = (st != EMPTY) && out_enq__RDY.

EMPTY:
- in_deq__ENA = take.
- If take: buf <= in_first, st <= W0.

W0:
- out_enq_v = first word of buf, selected by HI_FIRST.
- out_enq__ENA = send.
- If send: st <= W1.

W1:
- out_enq_v = second word of buf.
- out_enq__ENA = send.
- If send and take: in_deq__ENA = 1, buf <= in_first, st <= W0, pair_count += 1. This is back-to-back reload.
- If send and not take: st <= EMPTY, pair_count += 1.

General rules:
- in_deq__ENA is 0 in W0, and 0 in W1 when send is low.
- out_enq__ENA is 0 in EMPTY. In EMPTY, out_enq_v is driven as 0.
- in_deq__ENA and out_enq__ENA are combinational from st and the RDY inputs. All other outputs are registered, or decoded from st and buf.
- pair_count wraps from 2^CNT_W-1 to 0 with no flag.
- The upstream guard changing while in W0/W1 has no effect; buf is never overwritten except on a deq fire.
- Downstream stall (out_enq__RDY low) holds st, buf and out_enq_v stable for any number of cycles.

## Timing
- Reset (RST high at a posedge): st = EMPTY, buf = 0, pair_count = 0. Outputs: idle = 1, in_deq__ENA = 0, out_enq__ENA = 0, out_enq_v = 0. Reset overrides any simultaneous fire.
- The first in_deq__ENA can assert in the first cycle after reset deasserts.
- Latency: deq fire in cycle N puts the first word on out_enq_v in cycle N+1. The earliest second word is N+2.
- Throughput: 2 cycles per pair sustained, with a deq every other cycle and no bubble between pairs.
- Single pair, no stall: idle is low for exactly 2 cycles.
- RST asserted mid-pair: buf contents are discarded and no word is emitted. The upstream value already dequeued is lost by design.

## Test plan
- Reset: hold RST 3 cycles with all RDY high -> in_deq__ENA = 0, out_enq__ENA = 0, pair_count = 0, idle = 1. The first deq fires the cycle after RST falls.
- Single pair: HI_FIRST = 0, in_first = 64'h11112222_33334444, all RDY high -> words 32'h33334444 then 32'h11112222 on consecutive cycles, then pair_count = 1, idle = 1.
- Streaming: 4 pairs presented continuously, out_enq__RDY held at 1 -> 8 words in 8 consecutive cycles, in_deq__ENA on cycles 0, 2, 4, 6, pair_count = 4.
- Stall: out_enq__RDY = 0 for 5 cycles while in W1 -> out_enq_v is held, no deq fires, and the second word is delivered on the cycle RDY returns.
- Order/guard: HI_FIRST = 1, in_first__RDY = 1 but in_deq__RDY = 0 -> no deq. After a deq, high word 32'hAAAA0000 precedes low word 32'h0000BBBB.
- Wrap/reset: CNT_W = 2, 5 pairs -> pair_count = 1. RST asserted while in W0 -> next cycle idle = 1 with no word emitted.

Source files
------------

// File: rtl/pair_drain_if.sv
// Handshake bundle between the pair FIFO, the drain stage and the next stage.
// The drain stage takes the slave view; the environment around it takes master.
interface pair_drain_if;
    logic [63:0] in_first;
    logic        in_first__RDY;
    logic        in_deq__RDY;
    logic        in_deq__ENA;
    logic [31:0] out_enq_v;
    logic        out_enq__RDY;
    logic        out_enq__ENA;

    modport master (
        output in_first, in_first__RDY, in_deq__RDY, out_enq__RDY,
        input  in_deq__ENA, out_enq_v, out_enq__ENA
    );

    modport slave (
        input  in_first, in_first__RDY, in_deq__RDY, out_enq__RDY,
        output in_deq__ENA, out_enq_v, out_enq__ENA
    );
endinterface

// File: rtl/pair_drain.sv
// Drains 64-bit pairs from a one-entry FIFO and emits them as two 32-bit words,
// releasing the FIFO slot as soon as the pair is captured locally.
module pair_drain #(
    parameter bit HI_FIRST = 1'b0,
    parameter int CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             RST,
    pair_drain_if.slave      bus,
    output logic [CNT_W-1:0] pair_count,
    output logic             idle
);
    typedef enum logic [1:0] {EMPTY, W0, W1} state_t;

    state_t            st, st_nxt;
    logic [63:0]       buf_q, buf_nxt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              take, send;
    logic              deq_ena, enq_ena;
    logic [31:0]       enq_v;
    logic [31:0]       word_first, word_second;

    assign take        = bus.in_first__RDY && bus.in_deq__RDY;
    assign send        = (st != EMPTY) && bus.out_enq__RDY;
    assign word_first  = HI_FIRST ? buf_q[63:32] : buf_q[31:0];
    assign word_second = HI_FIRST ? buf_q[31:0]  : buf_q[63:32];

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        st_nxt  = st;
        buf_nxt = buf_q;
        cnt_nxt = pair_count;
        deq_ena = 1'b0;
        enq_ena = 1'b0;
        enq_v   = '0;
        case (st)
            EMPTY: begin
                deq_ena = take;
                if (take) begin
                    buf_nxt = bus.in_first;
                    st_nxt  = W0;
                end
            end
            W0: begin
                enq_v   = word_first;
                enq_ena = send;
                if (send) st_nxt = W1;
            end
            W1: begin
                enq_v   = word_second;
                enq_ena = send;
                if (send) begin
                    cnt_nxt = pair_count + CNT_W'(1);
                    if (take) begin
                        deq_ena = 1'b1;
                        buf_nxt = bus.in_first;
                        st_nxt  = W0;
                    end else begin
                        st_nxt  = EMPTY;
                    end
                end
            end
            default: st_nxt = EMPTY;
        endcase
        // Reset wins over any fire, so nothing is dequeued or emitted while it is held.
        if (RST) begin
            deq_ena = 1'b0;
            enq_ena = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update together on the edge.
    // NOTE: buf is reset too, so out_enq_v and any later read never expose stale data after reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            st         <= EMPTY;
            buf_q      <= '0;
            pair_count <= '0;
        end else begin
            st         <= st_nxt;
            buf_q      <= buf_nxt;
            pair_count <= cnt_nxt;
        end
    end

    assign bus.in_deq__ENA  = deq_ena;
    assign bus.out_enq__ENA = enq_ena;
    assign bus.out_enq_v    = enq_v;
    assign idle             = (st == EMPTY);
endmodule

// File: tb/tb_pair_drain.sv
// Drives two drain stages (low-first/16-bit count, high-first/2-bit count) with shared
// stimulus and scores them against a word-queue reference model.
module tb_pair_drain;
    logic        CLK = 1'b0;
    logic        rst;
    logic [63:0] in_first;
    logic        first_rdy, deq_rdy, enq_rdy;

    pair_drain_if if0 ();
    pair_drain_if if1 ();

    logic [15:0] cnt0;
    logic [1:0]  cnt1;
    logic        idle0, idle1;

    pair_drain #(.HI_FIRST(1'b0), .CNT_W(16)) dut0 (
        .CLK(CLK), .RST(rst), .bus(if0.slave), .pair_count(cnt0), .idle(idle0)
    );
    pair_drain #(.HI_FIRST(1'b1), .CNT_W(2)) dut1 (
        .CLK(CLK), .RST(rst), .bus(if1.slave), .pair_count(cnt1), .idle(idle1)
    );

    assign if0.in_first      = in_first;
    assign if0.in_first__RDY = first_rdy;
    assign if0.in_deq__RDY   = deq_rdy;
    assign if0.out_enq__RDY  = enq_rdy;
    assign if1.in_first      = in_first;
    assign if1.in_first__RDY = first_rdy;
    assign if1.in_deq__RDY   = deq_rdy;
    assign if1.out_enq__RDY  = enq_rdy;

    always #5 CLK = ~CLK;

    // Per-instance views of the DUT outputs
    logic        deq_ena [2];
    logic        enq_ena [2];
    logic [31:0] enq_v   [2];
    logic [15:0] cnt     [2];
    logic        idle_o  [2];
    assign deq_ena[0] = if0.in_deq__ENA;
    assign deq_ena[1] = if1.in_deq__ENA;
    assign enq_ena[0] = if0.out_enq__ENA;
    assign enq_ena[1] = if1.out_enq__ENA;
    assign enq_v[0]   = if0.out_enq_v;
    assign enq_v[1]   = if1.out_enq_v;
    assign cnt[0]     = cnt0;
    assign cnt[1]     = {14'b0, cnt1};
    assign idle_o[0]  = idle0;
    assign idle_o[1]  = idle1;

    localparam bit          HF   [2] = '{1'b0, 1'b1};
    localparam logic [15:0] MASK [2] = '{16'hFFFF, 16'h0003};

    typedef struct packed {
        logic [31:0] w;
        logic        last;
    } ent_t;

    // Reference model: words still owed downstream, and pairs completed so far
    ent_t        exp_q [2][$];
    int unsigned pairs [2];

    int checks = 0;
    int errors = 0;

    task automatic check(input int inst, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d t=%0t actual=%h expected=%h", name, inst, $time, act, exp);
        end
    endtask

    int   n_pend;
    bit   exp_enq, exp_deq;
    ent_t ent;

    // Monitor/scoreboard: runs mid-cycle, when combinational outputs have settled
    always @(negedge CLK) begin
        for (int i = 0; i < 2; i++) begin
            n_pend = exp_q[i].size();
            if (rst) begin
                check(i, "deq_ena_rst", 64'(deq_ena[i]), 64'(1'b0));
                check(i, "enq_ena_rst", 64'(enq_ena[i]), 64'(1'b0));
                exp_q[i].delete();
                pairs[i] = 0;
            end else begin
                exp_enq = (n_pend > 0) && enq_rdy;
                exp_deq = first_rdy && deq_rdy && (n_pend == 0 || (n_pend == 1 && enq_rdy));
                check(i, "enq_ena", 64'(enq_ena[i]), 64'(exp_enq));
                check(i, "deq_ena", 64'(deq_ena[i]), 64'(exp_deq));
                check(i, "out_enq_v", 64'(enq_v[i]), (n_pend > 0) ? 64'(exp_q[i][0].w) : 64'd0);
                check(i, "idle", 64'(idle_o[i]), 64'(n_pend == 0));
                check(i, "pair_count", 64'(cnt[i]), 64'(16'(pairs[i]) & MASK[i]));
                if (exp_enq) begin
                    ent = exp_q[i].pop_front();
                    if (ent.last) pairs[i]++;
                end
                if (exp_deq) begin
                    exp_q[i].push_back('{w: HF[i] ? in_first[63:32] : in_first[31:0], last: 1'b0});
                    exp_q[i].push_back('{w: HF[i] ? in_first[31:0] : in_first[63:32], last: 1'b1});
                end
            end
        end
    end

    task automatic drive(input bit r, input logic [63:0] d, input bit fr, input bit dr, input bit er, input int n);
        rst       = r;
        in_first  = d;
        first_rdy = fr;
        deq_rdy   = dr;
        enq_rdy   = er;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        // Reset held with every RDY high: nothing may fire
        drive(1'b1, 64'hDEAD_BEEF_CAFE_F00D, 1'b1, 1'b1, 1'b1, 3);
        // Single pair, deq on the first cycle out of reset
        drive(1'b0, 64'h11112222_33334444, 1'b1, 1'b1, 1'b1, 1);
        drive(1'b0, 64'h0, 1'b0, 1'b1, 1'b1, 4);
        // Streaming: 4 pairs back-to-back
        for (int k = 0; k < 4; k++)
            drive(1'b0, {$urandom, $urandom}, 1'b1, 1'b1, 1'b1, 2);
        drive(1'b0, 64'h0, 1'b0, 1'b1, 1'b1, 3);
        // Stall in W1 with upstream offering a new pair throughout
        drive(1'b0, 64'h55556666_77778888, 1'b1, 1'b1, 1'b1, 1);
        drive(1'b0, 64'h0, 1'b0, 1'b1, 1'b1, 1);
        drive(1'b0, 64'h99990000_12345678, 1'b1, 1'b1, 1'b0, 5);
        drive(1'b0, 64'h0, 1'b0, 1'b1, 1'b1, 3);
        // Guard: head valid but deq not ready, then one deq
        drive(1'b0, 64'hAAAA0000_0000BBBB, 1'b1, 1'b0, 1'b1, 3);
        drive(1'b0, 64'hAAAA0000_0000BBBB, 1'b1, 1'b1, 1'b1, 1);
        drive(1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 3);
        // Wrap: 5 more pairs streamed
        for (int k = 0; k < 5; k++)
            drive(1'b0, {$urandom, $urandom}, 1'b1, 1'b1, 1'b1, 2);
        drive(1'b0, 64'h0, 1'b0, 1'b1, 1'b1, 3);
        // Reset while in W0: the buffered pair is discarded
        drive(1'b0, 64'hFEEDFACE_0BADBEEF, 1'b1, 1'b1, 1'b1, 1);
        drive(1'b1, 64'h0, 1'b1, 1'b1, 1'b1, 1);
        drive(1'b0, 64'h0, 1'b0, 1'b1, 1'b1, 3);
        // Randomized traffic with occasional resets
        for (int k = 0; k < 3000; k++)
            drive(($urandom_range(0, 63) == 0), {$urandom, $urandom},
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 3) != 0), 1);
        drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
